// File: rtl/cache_arbiter_if.sv
// Bus bundle between the two cache clients, the arbiter and the memory port.
// slave  : arbiter view (client requests and memory response come in).
// master : environment view (caches and memory drive the requests/response).
interface cache_arbiter_if #(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
);
    logic              icache_pmem_read;
    logic [ADDR_W-1:0] icache_pmem_address;
    logic [LINE_W-1:0] icache_pmem_rdata;
    logic              icache_pmem_resp;

    logic              dcache_pmem_read;
    logic              dcache_pmem_write;
    logic [ADDR_W-1:0] dcache_pmem_address;
    logic [LINE_W-1:0] dcache_pmem_wdata;
    logic [LINE_W-1:0] dcache_pmem_rdata;
    logic              dcache_pmem_resp;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_resp;

    modport slave (
        input  icache_pmem_read, icache_pmem_address,
        output icache_pmem_rdata, icache_pmem_resp,
        input  dcache_pmem_read, dcache_pmem_write, dcache_pmem_address, dcache_pmem_wdata,
        output dcache_pmem_rdata, dcache_pmem_resp,
        output mem_read, mem_write, mem_address, mem_wdata,
        input  mem_rdata, mem_resp
    );

    modport master (
        output icache_pmem_read, icache_pmem_address,
        input  icache_pmem_rdata, icache_pmem_resp,
        output dcache_pmem_read, dcache_pmem_write, dcache_pmem_address, dcache_pmem_wdata,
        input  dcache_pmem_rdata, dcache_pmem_resp,
        input  mem_read, mem_write, mem_address, mem_wdata,
        output mem_rdata, mem_resp
    );
endinterface

// File: rtl/cache_arbiter.sv
// Two-client arbiter sharing one line-wide memory port between icache and
// dcache. One transaction at a time; ties go to the client not served last.
module cache_arbiter #(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    cache_arbiter_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_last_d;      // 1: dcache was served most recently
    logic              r_mem_read;
    logic              r_mem_write;
    logic [ADDR_W-1:0] r_mem_address;
    logic [LINE_W-1:0] r_mem_wdata;

    logic w_req_i;
    logic w_req_d;
    logic w_pick_d;
    logic w_pick_i;

    assign w_req_i  = bus.icache_pmem_read;
    assign w_req_d  = bus.dcache_pmem_read | bus.dcache_pmem_write;
    // Dcache wins when alone, or on a tie when icache was served last.
    assign w_pick_d = w_req_d & (~w_req_i | ~r_last_d);
    assign w_pick_i = w_req_i & ~w_pick_d;

    // Arbitration FSM; strobes, address and wdata are registered on the grant
    // edge so the memory port never sees a combinational path from clients.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_last_d      <= 1'b0;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_mem_address <= '0;
            r_mem_wdata   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick_d) begin
                        r_state       <= SERVE_D;
                        r_last_d      <= 1'b1;
                        r_mem_address <= bus.dcache_pmem_address;
                        r_mem_wdata   <= bus.dcache_pmem_wdata;
                        // A simultaneous read+write resolves to the write-back.
                        r_mem_write   <= bus.dcache_pmem_write;
                        r_mem_read    <= ~bus.dcache_pmem_write;
                    end else if (w_pick_i) begin
                        r_state       <= SERVE_I;
                        r_last_d      <= 1'b0;
                        r_mem_address <= bus.icache_pmem_address;
                        r_mem_read    <= 1'b1;
                        r_mem_write   <= 1'b0;
                    end
                end
                SERVE_I, SERVE_D: begin
                    if (bus.mem_resp) begin
                        r_state     <= IDLE;
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_mem_read  <= 1'b0;
                    r_mem_write <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_read    = r_mem_read;
    assign bus.mem_write   = r_mem_write;
    assign bus.mem_address = r_mem_address;
    assign bus.mem_wdata   = r_mem_wdata;

    // Completion is forwarded in the same cycle; rdata is a plain mirror and
    // only the resp of the granted client qualifies it.
    assign bus.icache_pmem_resp  = (r_state == SERVE_I) & bus.mem_resp;
    assign bus.dcache_pmem_resp  = (r_state == SERVE_D) & bus.mem_resp;
    assign bus.icache_pmem_rdata = bus.mem_rdata;
    assign bus.dcache_pmem_rdata = bus.mem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: directed scenarios plus randomized
// client/memory traffic compared every cycle against a transaction-level model.
module tb_cache_arbiter;
    localparam int LW = 256;
    localparam int AW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cache_arbiter_if #(.LINE_W(LW), .ADDR_W(AW)) bus ();
    cache_arbiter #(.LINE_W(LW), .ADDR_W(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_chk  = 0;
    int n_pass = 0;

    bit chk_en    = 1'b0;
    bit mem_auto  = 1'b1;
    bit rand_mode = 1'b0;
    int mem_lat   = 0;   // <0: random 0..4 extra cycles
    int cyc       = 0;

    // model: who owns the memory port and what was captured at grant
    int          m_busy;  // 0 none, 1 icache, 2 dcache
    logic [AW-1:0] m_addr;
    logic [LW-1:0] m_wdata;
    bit          m_wr;
    bit          m_last_d;

    // monitor statistics
    int n_rd, n_wr, n_iresp, n_dresp;
    int i_resp_cyc, d_resp_cyc;
    logic [AW-1:0] last_addr;
    logic [LW-1:0] last_wdata;
    bit i_seen = 1'b0;
    bit d_seen = 1'b0;
    int order_q[$];      // 1 = icache completed, 2 = dcache completed

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [LW-1:0] rnd_line();
        logic [LW-1:0] r;
        for (int k = 0; k < LW/32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic clear_stats();
        n_rd = 0; n_wr = 0; n_iresp = 0; n_dresp = 0;
        i_resp_cyc = 0; d_resp_cyc = 0;
        last_addr = '0; last_wdata = '0;
        order_q.delete();
    endtask

    // Wait until no client is requesting and the port is quiet; bounded.
    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while ((bus.icache_pmem_read || bus.dcache_pmem_read || bus.dcache_pmem_write ||
                    bus.mem_read || bus.mem_write) && k < budget);
        if (k >= budget) begin
            n_chk++;
            $display("FAIL wait_idle: timeout after %0d cycles", k);
        end
    endtask

    // Transaction-level reference: one owner at a time, fair tie-break.
    initial forever begin
        @(posedge clk);
        cyc++;
        if (rst) begin
            m_busy = 0; m_addr = '0; m_wdata = '0; m_wr = 1'b0; m_last_d = 1'b0;
        end else if (m_busy == 0) begin
            bit ri, rd;
            int pick;
            ri = bus.icache_pmem_read;
            rd = bus.dcache_pmem_read | bus.dcache_pmem_write;
            pick = 0;
            if (ri && rd) pick = m_last_d ? 1 : 2;
            else if (ri)  pick = 1;
            else if (rd)  pick = 2;
            if (pick == 1) begin
                m_busy = 1; m_addr = bus.icache_pmem_address; m_last_d = 1'b0;
            end else if (pick == 2) begin
                m_busy = 2; m_addr = bus.dcache_pmem_address; m_last_d = 1'b1;
                m_wr = bus.dcache_pmem_write; m_wdata = bus.dcache_pmem_wdata;
            end
        end else if (bus.mem_resp) begin
            m_busy = 0;
        end
    end

    // Per-cycle compare against the model, plus statistics for directed tests.
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            bit e_rd, e_wr, e_ir, e_dr;
            e_rd = (m_busy == 1) || (m_busy == 2 && !m_wr);
            e_wr = (m_busy == 2) && m_wr;
            e_ir = (m_busy == 1) && bus.mem_resp;
            e_dr = (m_busy == 2) && bus.mem_resp;
            check("mem_read",    bus.mem_read,         e_rd);
            check("mem_write",   bus.mem_write,        e_wr);
            check("mem_address", bus.mem_address,      m_addr);
            check("mem_wdata",   bus.mem_wdata,        m_wdata);
            check("icache_resp", bus.icache_pmem_resp, e_ir);
            check("dcache_resp", bus.dcache_pmem_resp, e_dr);
            if (e_ir) check("icache_rdata", bus.icache_pmem_rdata, bus.mem_rdata);
            if (e_dr) check("dcache_rdata", bus.dcache_pmem_rdata, bus.mem_rdata);
        end
        if (bus.mem_read)  n_rd++;
        if (bus.mem_write) n_wr++;
        if (bus.mem_read || bus.mem_write) begin
            last_addr  = bus.mem_address;
            last_wdata = bus.mem_wdata;
        end
        i_seen = bus.icache_pmem_resp;
        d_seen = bus.dcache_pmem_resp;
        if (i_seen) begin n_iresp++; i_resp_cyc = cyc; order_q.push_back(1); end
        if (d_seen) begin n_dresp++; d_resp_cyc = cyc; order_q.push_back(2); end
    end

    // Memory responder: answers a strobe after a programmable latency.
    initial begin
        int cnt;
        cnt = -1;
        forever begin
            @(posedge clk);
            #1;
            if (mem_auto) begin
                bus.mem_resp  = 1'b0;
                bus.mem_rdata = rnd_line();
                if (bus.mem_read || bus.mem_write) begin
                    if (cnt < 0) cnt = (mem_lat < 0) ? int'($urandom_range(0, 4)) : mem_lat;
                    if (cnt == 0) begin
                        bus.mem_resp = 1'b1;
                        cnt = -1;
                    end else cnt--;
                end else begin
                    cnt = -1;
                    if (rand_mode && $urandom_range(0, 15) == 0) bus.mem_resp = 1'b1;
                end
            end
        end
    end

    // Client behaviour: drop a request the cycle after its resp; random traffic.
    initial forever begin
        @(posedge clk);
        #1;
        if (i_seen) bus.icache_pmem_read = 1'b0;
        else if (rand_mode) begin
            if (!bus.icache_pmem_read) begin
                if ($urandom_range(0, 3) == 0) begin
                    bus.icache_pmem_read    = 1'b1;
                    bus.icache_pmem_address = $urandom & 32'hFFFF_FFE0;
                end
            end else if ($urandom_range(0, 7) == 0) bus.icache_pmem_address = $urandom;
        end
        if (d_seen) begin
            bus.dcache_pmem_read  = 1'b0;
            bus.dcache_pmem_write = 1'b0;
        end else if (rand_mode) begin
            if (!(bus.dcache_pmem_read || bus.dcache_pmem_write)) begin
                if ($urandom_range(0, 3) == 0) begin
                    int op;
                    op = $urandom_range(0, 2);
                    bus.dcache_pmem_read    = (op != 1);
                    bus.dcache_pmem_write   = (op != 0);
                    bus.dcache_pmem_address = $urandom & 32'hFFFF_FFE0;
                    bus.dcache_pmem_wdata   = rnd_line();
                end
            end else if ($urandom_range(0, 7) == 0) begin
                bus.dcache_pmem_address = $urandom;
                bus.dcache_pmem_wdata   = rnd_line();
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [LW-1:0] pat;
        pat = {32{8'hA5}};
        rst = 1'b1;
        bus.icache_pmem_read = 1'b0; bus.icache_pmem_address = '0;
        bus.dcache_pmem_read = 1'b0; bus.dcache_pmem_write = 1'b0;
        bus.dcache_pmem_address = '0; bus.dcache_pmem_wdata = '0;
        bus.mem_resp = 1'b0; bus.mem_rdata = '0;
        clear_stats();
        repeat (2) @(posedge clk);
        #1 chk_en = 1'b1;

        // reset state
        @(negedge clk);
        check("rst_mem_read",  bus.mem_read, 1'b0);
        check("rst_mem_write", bus.mem_write, 1'b0);
        check("rst_mem_addr",  bus.mem_address, 32'h0);
        check("rst_mem_wdata", bus.mem_wdata, '0);
        check("rst_resps",     {bus.icache_pmem_resp, bus.dcache_pmem_resp}, 2'b00);
        @(posedge clk); #2 rst = 1'b0;

        // icache alone, 4 strobe cycles
        clear_stats(); mem_lat = 3;
        @(posedge clk); #2 bus.icache_pmem_read = 1'b1; bus.icache_pmem_address = 32'h0000_0060;
        wait_idle(50);
        check("t1_rd_cycles", n_rd, 4);
        check("t1_wr_cycles", n_wr, 0);
        check("t1_iresp",     n_iresp, 1);
        check("t1_dresp",     n_dresp, 0);
        check("t1_addr",      last_addr, 32'h60);

        // dcache write-back
        clear_stats(); mem_lat = 1;
        @(posedge clk); #2
        bus.dcache_pmem_write = 1'b1; bus.dcache_pmem_address = 32'h0000_1000; bus.dcache_pmem_wdata = pat;
        wait_idle(50);
        check("t2_wr_cycles", n_wr, 2);
        check("t2_rd_cycles", n_rd, 0);
        check("t2_dresp",     n_dresp, 1);
        check("t2_iresp",     n_iresp, 0);
        check("t2_wdata",     last_wdata, pat);
        check("t2_addr",      last_addr, 32'h1000);

        // ties right after reset: dcache first, then strict alternation
        @(posedge clk); #2 rst = 1'b1;
        @(posedge clk); #2 rst = 1'b0;
        clear_stats(); mem_lat = 0;
        for (int t = 0; t < 4; t++) begin
            @(posedge clk); #2
            bus.icache_pmem_read = 1'b1; bus.icache_pmem_address = 32'h100 + t*64;
            bus.dcache_pmem_read = 1'b1; bus.dcache_pmem_address = 32'h8000 + t*64;
            wait_idle(50);
            if (t == 0) check("t3_i_after_d", i_resp_cyc - d_resp_cyc, 2);
        end
        check("t3_order_len", order_q.size(), 8);
        for (int j = 0; j < 8 && j < order_q.size(); j++)
            check("t3_order", order_q[j], (j % 2 == 0) ? 2 : 1);

        // read+write together resolves to write
        clear_stats(); mem_lat = 0;
        @(posedge clk); #2
        bus.dcache_pmem_read = 1'b1; bus.dcache_pmem_write = 1'b1;
        bus.dcache_pmem_address = 32'h2000; bus.dcache_pmem_wdata = rnd_line();
        wait_idle(50);
        check("t4_wr_cycles", n_wr, 1);
        check("t4_rd_cycles", n_rd, 0);
        check("t4_dresp",     n_dresp, 1);

        // address held while the client changes its address
        clear_stats(); mem_lat = 4;
        @(posedge clk); #2 bus.icache_pmem_read = 1'b1; bus.icache_pmem_address = 32'h300;
        repeat (2) @(posedge clk);
        #2 bus.icache_pmem_address = 32'hDEAD_0000;
        @(negedge clk);
        check("t5_addr_hold", bus.mem_address, 32'h300);
        check("t5_read_on",   bus.mem_read, 1'b1);
        wait_idle(50);

        // reset while serving dcache, then stray resp in IDLE, then normal grant
        clear_stats(); mem_lat = 20;
        @(posedge clk); #2 bus.dcache_pmem_read = 1'b1; bus.dcache_pmem_address = 32'h4000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("t6_serving", bus.mem_read, 1'b1);
        @(posedge clk); #2 rst = 1'b1; bus.dcache_pmem_read = 1'b0;
        @(posedge clk); #2 rst = 1'b0;
        @(negedge clk);
        check("t6_strobes_off", {bus.mem_read, bus.mem_write}, 2'b00);
        check("t6_resps_off",   {bus.icache_pmem_resp, bus.dcache_pmem_resp}, 2'b00);
        mem_auto = 1'b0;
        @(posedge clk); #2 bus.mem_resp = 1'b1;
        @(negedge clk);
        check("t6_stray_resp", {bus.icache_pmem_resp, bus.dcache_pmem_resp}, 2'b00);
        @(posedge clk); #2 bus.mem_resp = 1'b0; mem_auto = 1'b1; mem_lat = 1;
        @(posedge clk); #2 bus.icache_pmem_read = 1'b1; bus.icache_pmem_address = 32'h80;
        wait_idle(50);
        check("t6_iresp_after", n_iresp, 1);
        check("t6_dresp_none",  n_dresp, 0);

        // randomized traffic with occasional resets
        clear_stats(); mem_lat = -1; rand_mode = 1'b1;
        for (int r = 0; r < 3000; r++) begin
            @(posedge clk);
            if (r % 700 == 350) begin
                #2 rst = 1'b1;
                @(posedge clk); #2 rst = 1'b0;
            end
        end
        rand_mode = 1'b0;
        wait_idle(100);
        check("rand_i_served", n_iresp > 0, 1'b1);
        check("rand_d_served", n_dresp > 0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
